// File: rtl/seq_pkg.sv
// Shared state encoding for the core's multi-cycle execution sequencer.
package seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        OPREAD = 3'd3,
        EXEC   = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERROR  = 3'd7
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Per-phase wait counter: raises limit_hit combinationally on the cycle the
// TIMEOUT_CYCLES-th consecutive waiting cycle is observed.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign limit_hit = count_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the single-issue core: fetch, decode, operand
// read, execute and write-back with handshakes, stop/resume and a watchdog.
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RET_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   instr_valid,
    output logic                   next_instr,
    input  logic                   dec_rd_wr_en,
    input  logic                   dec_rs_store,
    output logic                   rs_addr_valid,
    input  logic                   op_done,
    input  logic                   alu_data_valid,
    output logic                   wb_en,
    output logic                   busy,
    output logic                   err,
    output logic [RET_W-1:0]       retired,
    output logic [SEQ_STATE_W-1:0] state_dbg
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             r_rd_wr_en;
    logic             r_rs_store;
    logic             r_stop_pend;
    logic             r_next_instr;
    logic             r_rs_addr_valid;
    logic             r_wb_en;
    logic             r_err;
    logic [RET_W-1:0] r_retired;
    logic             w_retire;
    logic             w_wait;
    logic             w_timeout;
    logic             w_busy;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_next != r_state),
        .count_en (w_wait),
        .limit_hit(w_timeout)
    );

    assign w_busy = (r_state == FETCH) || (r_state == DECODE) || (r_state == OPREAD) ||
                    (r_state == EXEC)  || (r_state == WB);

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_wait   = 1'b0;
        case (r_state)
            IDLE:   if (start) w_next = FETCH;
            FETCH:  if (instr_valid) w_next = DECODE; else w_wait = 1'b1;
            DECODE: w_next = OPREAD;
            OPREAD: begin
                if (op_done) begin
                    if (r_rs_store) w_retire = 1'b1;
                    else            w_next   = EXEC;
                end else begin
                    w_wait = 1'b1;
                end
            end
            EXEC: begin
                if (alu_data_valid) begin
                    if (r_rd_wr_en) w_next   = WB;
                    else            w_retire = 1'b1;
                end else begin
                    w_wait = 1'b1;
                end
            end
            WB:     w_retire = 1'b1;
            HALT:   if (start && !stop) w_next = FETCH;
            ERROR:  w_next = ERROR;
            default: w_next = ERROR;
        endcase
        // A stop seen on the retiring cycle itself must still land in HALT.
        if (w_retire) w_next = (r_stop_pend || stop) ? HALT : FETCH;
        if (w_timeout) w_next = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rd_wr_en      <= 1'b0;
            r_rs_store      <= 1'b0;
            r_stop_pend     <= 1'b0;
            r_next_instr    <= 1'b0;
            r_rs_addr_valid <= 1'b0;
            r_wb_en         <= 1'b0;
            r_err           <= 1'b0;
            r_retired       <= '0;
        end else begin
            r_state         <= w_next;
            r_next_instr    <= (w_next == FETCH)  && (r_state != FETCH);
            r_rs_addr_valid <= (w_next == OPREAD) && (r_state != OPREAD);
            r_wb_en         <= (w_next == WB)     && (r_state != WB);
            if (r_state == DECODE) begin
                r_rd_wr_en <= dec_rd_wr_en;
                r_rs_store <= dec_rs_store;
            end
            if (w_retire) r_retired <= r_retired + RET_W'(1);
            if (w_next == ERROR) r_err <= 1'b1;
            if (r_state == HALT && w_next == FETCH) r_stop_pend <= 1'b0;
            else if (w_busy && stop)                r_stop_pend <= 1'b1;
        end
    end

    assign next_instr    = r_next_instr;
    assign rs_addr_valid = r_rs_addr_valid;
    assign wb_en         = r_wb_en;
    assign busy          = w_busy;
    assign err           = r_err;
    assign retired       = r_retired;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus randomized
// instruction streams checked against a phase-level schedule model.
module tb_exec_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned RW = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_OPREAD = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    logic          clk = 1'b0;
    logic          reset, start, stop, instr_valid, dec_rd_wr_en, dec_rs_store;
    logic          op_done, alu_data_valid;
    logic          next_instr, rs_addr_valid, wb_en, busy, err;
    logic [RW-1:0] retired;
    logic [2:0]    state_dbg;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          ic;
    int          stop_at = -1;
    int unsigned stop_rate = 0;
    bit          stop_seen;
    int unsigned m_ret = 0;

    always #5 clk = ~clk;

    exec_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .RET_W         (RW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .instr_valid   (instr_valid),
        .next_instr    (next_instr),
        .dec_rd_wr_en  (dec_rd_wr_en),
        .dec_rs_store  (dec_rs_store),
        .rs_addr_valid (rs_addr_valid),
        .op_done       (op_done),
        .alu_data_valid(alu_data_valid),
        .wb_en         (wb_en),
        .busy          (busy),
        .err           (err),
        .retired       (retired),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [2:0] strb);
        check({tag, ".state"}, 32'(state_dbg), 32'(st));
        check({tag, ".strobes"}, 32'({next_instr, rs_addr_valid, wb_en}), 32'(strb));
        check({tag, ".busy"}, 32'(busy), 32'(st >= S_FETCH && st <= S_WB));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        instr_valid    = 1'($urandom_range(0, 1));
        op_done        = 1'($urandom_range(0, 1));
        alu_data_valid = 1'($urandom_range(0, 1));
        dec_rd_wr_en   = 1'($urandom_range(0, 1));
        dec_rs_store   = 1'($urandom_range(0, 1));
    endtask

    // start is irrelevant while busy; stop is driven per plan and remembered.
    task automatic tick_busy();
        start = 1'($urandom_range(0, 1));
        stop  = (ic == stop_at) || (stop_rate != 0 && $urandom_range(0, stop_rate - 1) == 0);
        if (stop) stop_seen = 1'b1;
        tick();
        ic++;
        stop = 1'b0;
    endtask

    task automatic run_instr(input int unsigned df, input int unsigned dop, input int unsigned de,
                             input bit wr, input bit st);
        stop_seen = 1'b0;
        ic = 0;
        for (int unsigned k = 0; k <= df; k++) begin
            expect_cyc("fetch", S_FETCH, (k == 0) ? 3'b100 : 3'b000);
            noise();
            instr_valid = (k == df);
            tick_busy();
        end
        expect_cyc("decode", S_DECODE, 3'b000);
        noise();
        dec_rd_wr_en = wr;
        dec_rs_store = st;
        tick_busy();
        for (int unsigned k = 0; k <= dop; k++) begin
            expect_cyc("opread", S_OPREAD, (k == 0) ? 3'b010 : 3'b000);
            noise();
            op_done = (k == dop);
            tick_busy();
        end
        if (!st) begin
            for (int unsigned k = 0; k <= de; k++) begin
                expect_cyc("exec", S_EXEC, 3'b000);
                noise();
                alu_data_valid = (k == de);
                tick_busy();
            end
            if (wr) begin
                expect_cyc("wb", S_WB, 3'b001);
                noise();
                tick_busy();
            end
        end
        m_ret = (m_ret + 1) % (1 << RW);
        check("retired", 32'(retired), m_ret);
        check("err_clear", 32'(err), 0);
        if (stop_seen) expect_cyc("halt", S_HALT, 3'b000);
        else           expect_cyc("refetch", S_FETCH, 3'b100);
    endtask

    task automatic resume(input int unsigned wait_cycles);
        for (int unsigned n = 0; n < wait_cycles; n++) begin
            expect_cyc("halt_wait", S_HALT, 3'b000);
            noise();
            start = 1'($urandom_range(0, 1));
            stop  = start ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        expect_cyc("halt_exit", S_HALT, 3'b000);
        start = 1'b1;
        stop  = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        m_ret = 0;
        expect_cyc("reset", S_IDLE, 3'b000);
        check("reset.retired", 32'(retired), 0);
        check("reset.err", 32'(err), 0);
    endtask

    task automatic go_from_idle();
        expect_cyc("idle", S_IDLE, 3'b000);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        instr_valid = 1'b0; op_done = 1'b0; alu_data_valid = 1'b0;
        dec_rd_wr_en = 1'b0; dec_rs_store = 1'b0;
        tick();
        do_reset();

        // stop is ignored in IDLE, even together with start
        stop = 1'b1;
        tick();
        expect_cyc("idle_stop", S_IDLE, 3'b000);
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;

        // 5-cycle reg-reg op, then 3-cycle immediate store
        run_instr(0, 0, 0, 1'b1, 1'b0);
        run_instr(0, 0, 0, 1'b0, 1'b1);
        run_instr(0, 0, 0, 1'b0, 1'b0);

        // stop pulsed during EXEC: write-back still completes, then HALT
        stop_at = 3;
        run_instr(0, 0, 0, 1'b1, 1'b0);
        stop_at = -1;
        expect_cyc("halt_both", S_HALT, 3'b000);
        start = 1'b1; stop = 1'b1;
        tick();
        expect_cyc("halt_stay", S_HALT, 3'b000);
        stop = 1'b0;
        tick();
        start = 1'b0;
        run_instr(0, 0, 0, 1'b1, 1'b0);

        // longest legal waits in every phase
        run_instr(TO - 1, TO - 1, TO - 1, 1'b1, 1'b0);

        // counter wrap at 2^RW
        do_reset();
        go_from_idle();
        for (int i = 0; i < 16; i++)
            run_instr($urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("wrap.retired", 32'(retired), 0);
        check("wrap.err", 32'(err), 0);

        // randomized stream with random stops and resumes
        stop_rate = 6;
        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (stop_seen) resume($urandom_range(0, 3));
        end
        stop_rate = 0;

        // reset in the WB cycle abandons the instruction
        if (state_dbg == S_HALT) resume(0);
        instr_valid = 1'b1; op_done = 1'b1; alu_data_valid = 1'b1;
        dec_rd_wr_en = 1'b1; dec_rs_store = 1'b0;
        expect_cyc("rwb.f", S_FETCH, 3'b100);  tick();
        expect_cyc("rwb.d", S_DECODE, 3'b000); tick();
        expect_cyc("rwb.o", S_OPREAD, 3'b010); tick();
        expect_cyc("rwb.e", S_EXEC, 3'b000);   tick();
        expect_cyc("rwb.w", S_WB, 3'b001);
        do_reset();

        // fetch timeout: ERROR after TO waiting cycles, sticky until reset
        go_from_idle();
        for (int unsigned k = 0; k < TO; k++) begin
            expect_cyc("to_fetch", S_FETCH, (k == 0) ? 3'b100 : 3'b000);
            noise();
            instr_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            expect_cyc("to_error", S_ERROR, 3'b000);
            check("to_error.err", 32'(err), 1);
            noise();
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        do_reset();

        // execute timeout
        go_from_idle();
        instr_valid = 1'b1; op_done = 1'b1; alu_data_valid = 1'b0;
        dec_rd_wr_en = 1'b1; dec_rs_store = 1'b0;
        expect_cyc("tox.f", S_FETCH, 3'b100);  tick();
        expect_cyc("tox.d", S_DECODE, 3'b000); tick();
        expect_cyc("tox.o", S_OPREAD, 3'b010); tick();
        for (int unsigned k = 0; k < TO; k++) begin
            expect_cyc("tox.e", S_EXEC, 3'b000);
            tick();
        end
        expect_cyc("tox.error", S_ERROR, 3'b000);
        check("tox.err", 32'(err), 1);
        check("tox.retired", 32'(retired), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
